alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Front-end controller for the 8-bit combinational ALU. It accepts one register-to-register instruction at a time over a valid/ready handshake and reads operands from an internal 8x8 register file. It drives the ALU opcode, operand and status inputs, captures the ALU result and status outputs, then writes back the destination register and the status register. The block sits between the instruction issue logic and the ALU and owns the architectural register file and status byte.

Parameters:
STATUS_RESET, 8'h00, reset value of the status register
DATA_W, 8, datapath width; fixed at 8 to match the ALU

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept an instruction
instr  in  16  [15:11] aop, [10:8] rd, [7:5] rx, [4:2] ry, [1] imm_sel, [0] wb_en
imm  in  8  immediate operand, sampled with instr
alu_aop  out  5  opcode to the ALU
alu_x  out  8  X operand to the ALU
alu_y  out  8  Y operand to the ALU
alu_s  out  8  current status to the ALU
alu_o  in  8  ALU result
alu_os  in  8  ALU next-status
done  out  1  one-cycle pulse when an instruction retires
status  out  8  status register (bit0 = equal, bit1 = zero, others pass through)
dbg_sel  in  3  register-file debug read index
dbg_data  out  8  combinational read of reg[dbg_sel]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All 8 registers = 0; status = STATUS_RESET.
  - alu_aop, alu_x, alu_y, alu_s = 0; done = 0.
  - Internal instr/imm/result latches = 0.
- FSM: IDLE -> ISSUE -> CAPTURE -> WRITE -> IDLE.
  - instr_ready = 1 only in IDLE.
- IDLE: on instr_valid & instr_ready at edge N, latch instr and imm, go to ISSUE. Without valid, stay in IDLE.
- ISSUE: at edge N+1, register the ALU inputs, then go to CAPTURE:
  - alu_aop = aop
  - alu_x = reg[rx]
  - alu_y = imm_sel ? imm_q : reg[ry]
  - alu_s = status
- CAPTURE: the ALU inputs are stable for this whole cycle. At edge N+2, sample alu_o and alu_os into o_q and os_q, then go to WRITE.
- WRITE: at edge N+3:
  - status <= os_q.
  - If wb_en=1 and rd!=0, reg[rd] <= o_q.
  - done <= 1; go to IDLE.
- done is high for exactly the cycle after edge N+3. A new instruction can be accepted in that same cycle.
- Throughput: one instruction per 4 cycles. Latency: accept edge to done-high is 3 edges.
- ALU input hold: alu_* outputs hold their last value outside ISSUE updates. They change only at the ISSUE edge.
- r0 rule: reads of r0 return 0, and writes to r0 are discarded. dbg_sel=0 returns 0.
- Status always updates on retire, including when wb_en=0.
- Operand aliasing: rd==rx==ry is legal. Operands are read in ISSUE, before writeback, so no hazard exists.
- While not in IDLE, instr and imm are ignored; changes to them do not affect the in-flight operation.
- Opcode handling: unknown opcodes are passed through unchanged. The result is whatever the ALU returns.
- Reset mid-operation (any state): abort immediately, with no register or status write and no done pulse.
- dbg_data reflects a writeback starting from the cycle after edge N+3.

Test Plan:
- Reset: pulse rst_n low mid-cycle -> instr_ready=1, status=8'h00, done=0, alu_* = 0, dbg_data=0 for every dbg_sel.
- Immediate loads via RETY: load r1 with aop=00001, rd=1, imm_sel=1, wb_en=1, imm=8'h05; then load r2 with imm=8'hFB -> each gives done 3 edges after accept; dbg_sel=1 reads 05 and dbg_sel=2 reads FB.
- ADD and CMP:
  - ADD r3=r1+r2 (aop=00010) -> alu_x=05, alu_y=FB held through CAPTURE; reg3=00; status bit1=1.
  - Then CMP r1,r2 (aop=00100, wb_en=0) -> status bit0=0, bit1 still 1, reg3 unchanged.
- SUB and r0: SUB r4=r1-r1 gives reg4=00 and status bit1=1. Write-to-r0 test: ADD rd=0 -> dbg_sel=0 reads 0, while status still updates.
- Back-to-back: hold instr_valid=1 with 3 distinct instrs and change instr during busy cycles -> accepted only in IDLE (every 4 cycles), in-flight results unaffected, 3 done pulses.
- Abort: assert rst_n=0 during CAPTURE of ADD r5 -> no done pulse, reg5=0, status=STATUS_RESET, state IDLE after release.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU drive/return bus and debug read port of the ALU sequencer.
interface alu_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [DATA_W-1:0] imm;
  logic [4:0]        alu_aop;
  logic [DATA_W-1:0] alu_x;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_s;
  logic [DATA_W-1:0] alu_o;
  logic [DATA_W-1:0] alu_os;
  logic              done;
  logic [DATA_W-1:0] status;
  logic [2:0]        dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  // issue logic + ALU side
  modport master (
    output instr_valid, instr, imm, alu_o, alu_os, dbg_sel,
    input  instr_ready, alu_aop, alu_x, alu_y, alu_s, done, status, dbg_data
  );

  // sequencer side
  modport slave (
    input  instr_valid, instr, imm, alu_o, alu_os, dbg_sel,
    output instr_ready, alu_aop, alu_x, alu_y, alu_s, done, status, dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU front-end sequencer: owns the 8x8 register file and status byte, issues one
// register-to-register instruction to the combinational ALU every four cycles.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for an instruction; latches instr/imm on accept
// ISSUE   | reads operands and registers the ALU inputs
// CAPTURE | ALU inputs stable; samples ALU result and next-status
// WRITE   | commits status and destination register, pulses done
module alu_sequencer #(
  parameter logic [7:0] STATUS_RESET = 8'h00,
  parameter int         DATA_W       = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              ready;
  logic              accept;

  logic [15:0]       instr_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] o_q;
  logic [DATA_W-1:0] os_q;
  logic [DATA_W-1:0] status_q;
  logic [DATA_W-1:0] regs [0:7];

  logic [4:0]        aop_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] s_q;
  logic              done_q;

  logic [DATA_W-1:0] x_val;
  logic [DATA_W-1:0] ry_val;
  logic [DATA_W-1:0] dbg_val;

  logic [4:0]        f_aop;
  logic [2:0]        f_rd;
  logic [2:0]        f_rx;
  logic [2:0]        f_ry;
  logic              f_imm_sel;
  logic              f_wb_en;

  assign f_aop     = instr_q[15:11];
  assign f_rd      = instr_q[10:8];
  assign f_rx      = instr_q[7:5];
  assign f_ry      = instr_q[4:2];
  assign f_imm_sel = instr_q[1];
  assign f_wb_en   = instr_q[0];

  assign accept = bus.instr_valid & ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) state_d = ISSUE;
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand and debug reads; r0 is hard-wired to zero regardless of storage
  always_comb begin
    x_val   = (f_rx == 3'd0) ? '0 : regs[f_rx];
    ry_val  = (f_ry == 3'd0) ? '0 : regs[f_ry];
    dbg_val = (bus.dbg_sel == 3'd0) ? '0 : regs[bus.dbg_sel];
  end

  // Instruction latch, ALU drive registers, result capture, status and done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '0;
      imm_q    <= '0;
      aop_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      s_q      <= '0;
      o_q      <= '0;
      os_q     <= '0;
      status_q <= STATUS_RESET;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == WRITE);
      if (accept) begin
        instr_q <= bus.instr;
        imm_q   <= bus.imm;
      end
      if (state_q == ISSUE) begin
        aop_q <= f_aop;
        x_q   <= x_val;
        y_q   <= f_imm_sel ? imm_q : ry_val;
        s_q   <= status_q;
      end
      if (state_q == CAPTURE) begin
        o_q  <= bus.alu_o;
        os_q <= bus.alu_os;
      end
      if (state_q == WRITE) status_q <= os_q;
    end
  end

  // Register file writeback; r0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (state_q == WRITE && f_wb_en && f_rd != 3'd0) begin
      regs[f_rd] <= o_q;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.alu_aop     = aop_q;
  assign bus.alu_x       = x_q;
  assign bus.alu_y       = y_q;
  assign bus.alu_s       = s_q;
  assign bus.done        = done_q;
  assign bus.status      = status_q;
  assign bus.dbg_data    = dbg_val;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a stand-in ALU, an architectural model of
// the register file/status byte, directed cases and randomized instructions.
module tb_alu_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [7:0] m_reg [8];
  logic [7:0] m_status;

  alu_sequencer_if bus ();

  alu_sequencer #(.STATUS_RESET(8'h00), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: returns {next_status, result}
  function automatic logic [15:0] alu_ref(input logic [4:0] aop, input logic [7:0] x,
                                          input logic [7:0] y, input logic [7:0] s);
    logic [7:0] o;
    logic [7:0] os;
    case (aop)
      5'd1:       o = y;
      5'd2:       o = x + y;
      5'd3, 5'd4: o = x - y;
      default:    o = x ^ y ^ {3'b000, aop};
    endcase
    case (aop)
      5'd1, 5'd2, 5'd3: os = {s[7:2], (o == 8'h00), s[0]};
      5'd4:             os = {s[7:2], s[1], (x == y)};
      default:          os = s ^ {aop, 3'b000};
    endcase
    return {os, o};
  endfunction

  always_comb {bus.alu_os, bus.alu_o} = alu_ref(bus.alu_aop, bus.alu_x, bus.alu_y, bus.alu_s);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_status = 8'h00;
  endtask

  task automatic sweep_dbg(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus.dbg_sel = 3'(i);
      #1;
      check(tag, 32'(bus.dbg_data), 32'(m_reg[i]));
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.instr_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("ready_timeout", 32'(bus.instr_ready), 32'd1);
  endtask

  // One instruction with cycle-accurate checks of issue, hold, retire and writeback
  task automatic run_op(input logic [4:0] aop, input logic [2:0] rd, input logic [2:0] rx,
                        input logic [2:0] ry, input logic imm_sel, input logic wb_en,
                        input logic [7:0] imm);
    logic [7:0]  ex, ey, es;
    logic [15:0] r;
    @(negedge clk);
    bus.instr       = {aop, rd, rx, ry, imm_sel, wb_en};
    bus.imm         = imm;
    bus.instr_valid = 1'b1;
    wait_ready();
    ex = m_reg[rx];
    ey = imm_sel ? imm : m_reg[ry];
    es = m_status;
    r  = alu_ref(aop, ex, ey, es);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    bus.imm         = 8'($urandom);
    check("ready_busy", 32'(bus.instr_ready), 32'd0);
    @(posedge clk);
    #1;
    check("issue_aop", 32'(bus.alu_aop), 32'(aop));
    check("issue_x", 32'(bus.alu_x), 32'(ex));
    check("issue_y", 32'(bus.alu_y), 32'(ey));
    check("issue_s", 32'(bus.alu_s), 32'(es));
    check("done_early", 32'(bus.done), 32'd0);
    bus.instr = 16'($urandom);
    bus.imm   = 8'($urandom);
    @(posedge clk);
    #1;
    check("hold_x", 32'(bus.alu_x), 32'(ex));
    check("hold_y", 32'(bus.alu_y), 32'(ey));
    check("status_pre", 32'(bus.status), 32'(es));
    check("done_early", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    m_status = r[15:8];
    if (wb_en && rd != 3'd0) m_reg[rd] = r[7:0];
    check("done", 32'(bus.done), 32'd1);
    check("ready_done", 32'(bus.instr_ready), 32'd1);
    check("status", 32'(bus.status), 32'(m_status));
    bus.dbg_sel = rd;
    #1;
    check("wb_dbg", 32'(bus.dbg_data), 32'(m_reg[rd]));
  endtask

  // Valid held high; instr scrambled while busy, real instructions only when idle
  task automatic back_to_back();
    logic [15:0] prog [3];
    logic [7:0]  pimm [3];
    logic [7:0]  exp_st, exp_val, ey;
    logic [2:0]  exp_rd;
    logic [15:0] r;
    logic        exp_done, exp_ready;
    int          a_last = -100;
    int          k = 0;
    int          dones = 0;
    prog[0] = {5'd1, 3'd6, 3'd0, 3'd0, 1'b1, 1'b1}; pimm[0] = 8'h3C;
    prog[1] = {5'd2, 3'd7, 3'd6, 3'd6, 1'b0, 1'b1}; pimm[1] = 8'hAA;
    prog[2] = {5'd3, 3'd6, 3'd7, 3'd1, 1'b0, 1'b1}; pimm[2] = 8'h55;
    exp_st = 8'h00; exp_val = 8'h00; exp_rd = 3'd0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      exp_done  = (c == a_last + 4);
      exp_ready = (c >= a_last + 4);
      check("b2b_done", 32'(bus.done), 32'(exp_done));
      check("b2b_ready", 32'(bus.instr_ready), 32'(exp_ready));
      if (exp_done) begin
        dones++;
        check("b2b_status", 32'(bus.status), 32'(exp_st));
        bus.dbg_sel = exp_rd;
        #1;
        check("b2b_wb", 32'(bus.dbg_data), 32'(exp_val));
      end
      if (exp_ready && k < 3) begin
        bus.instr       = prog[k];
        bus.imm         = pimm[k];
        bus.instr_valid = 1'b1;
        ey = prog[k][1] ? pimm[k] : m_reg[prog[k][4:2]];
        r  = alu_ref(prog[k][15:11], m_reg[prog[k][7:5]], ey, m_status);
        m_status = r[15:8];
        exp_rd   = prog[k][10:8];
        if (prog[k][0] && exp_rd != 3'd0) m_reg[exp_rd] = r[7:0];
        exp_st  = m_status;
        exp_val = m_reg[exp_rd];
        a_last  = c;
        k++;
      end else if (exp_ready) begin
        bus.instr_valid = 1'b0;
      end else begin
        bus.instr       = 16'($urandom);
        bus.imm         = 8'($urandom);
        bus.instr_valid = 1'b1;
      end
    end
    check("b2b_count", 32'(dones), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] raop;
    n_checks        = 0;
    n_errors        = 0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.imm         = 8'h00;
    bus.dbg_sel     = 3'd0;
    rst_n           = 1'b1;
    model_reset();

    // Reset asserted mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_status", 32'(bus.status), 32'h00);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_alu", {bus.alu_aop, bus.alu_x, bus.alu_y, bus.alu_s[2:0]}, 32'd0);
    sweep_dbg("rst_dbg");
    @(negedge clk);
    rst_n = 1'b1;

    // Immediate loads, ADD, CMP, SUB, write to r0
    run_op(5'd1, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 8'h05);
    run_op(5'd1, 3'd2, 3'd0, 3'd0, 1'b1, 1'b1, 8'hFB);
    sweep_dbg("load_dbg");
    run_op(5'd2, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1, 8'h00);
    check("add_zero_flag", 32'(bus.status[1]), 32'd1);
    run_op(5'd4, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 8'h00);
    check("cmp_status", 32'(bus.status[1:0]), 32'h2);
    run_op(5'd3, 3'd4, 3'd1, 3'd1, 1'b0, 1'b1, 8'h00);
    run_op(5'd2, 3'd0, 3'd1, 3'd1, 1'b0, 1'b1, 8'h00);
    sweep_dbg("dir_dbg");

    back_to_back();
    @(negedge clk);
    bus.instr_valid = 1'b0;

    // Randomized instructions, including unknown opcodes and aliasing
    for (int i = 0; i < 40; i++) begin
      raop = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(1, 4));
      run_op(raop, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
             8'($urandom));
    end
    sweep_dbg("rand_dbg");

    // Abort during CAPTURE of ADD r5 = r1 + r2
    run_op(5'd1, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 8'h11);
    run_op(5'd1, 3'd2, 3'd0, 3'd0, 1'b1, 1'b1, 8'h22);
    @(negedge clk);
    bus.instr       = {5'd2, 3'd5, 3'd1, 3'd2, 1'b0, 1'b1};
    bus.imm         = 8'h00;
    bus.instr_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_ready", 32'(bus.instr_ready), 32'd1);
    check("abort_status", 32'(bus.status), 32'h00);
    check("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    check("abort_idle", 32'(bus.instr_ready), 32'd1);
    check("abort_status2", 32'(bus.status), 32'h00);
    sweep_dbg("abort_dbg");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
